xgmii_tx_sequencer: RTL and testbench
=====================================

XGMII_TX_SEQUENCER -- requirements
Module: xgmii_tx_sequencer

Interface
REQ-001 Parameters: DATA_WIDTH, 32, XGMII data width; CTRL_WIDTH, 4, XGMII control width; IFG_WORDS, 2, minimum idle words after a frame end (range 1..15).
REQ-002 Ports: i_clk  in  1  single clock, all logic on rising edge.
REQ-003 Ports: i_reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Ports: s_axis_tdata  in  32  frame data, byte 0 in bits [7:0], sent first on the wire.
REQ-005 Ports: s_axis_tkeep  in  4  byte-valid mask, meaningful on the tlast beat only.
REQ-006 Ports: s_axis_tvalid  in  1  source word valid.
REQ-007 Ports: s_axis_tlast  in  1  last word of frame.
REQ-008 Ports: s_axis_tready  out  1  word accepted when tvalid and tready are both high at an edge.
REQ-009 Ports: i_xgmii_pause  in  1  encoder pause; high means the encoder does not consume the current XGMII word.
REQ-010 Ports: o_xgmii_txd  out  32  XGMII data to the encoder.
REQ-011 Ports: o_xgmii_txc  out  4  XGMII control, bit n covers lane n.
REQ-012 Ports: o_busy  out  1  high in every state except IDLE.
REQ-013 Ports: o_underrun  out  1  one-cycle pulse on a mid-frame underrun.
REQ-014 Ports: o_frame_cnt  out  16  count of frames terminated normally, wraps at 0xFFFF->0.

Function
REQ-015 o_xgmii_txd/txc are registered; a word accepted at edge N appears on the outputs after edge N.
REQ-016 When i_xgmii_pause=1 at an edge, all state, counters and outputs hold, o_underrun is 0, and s_axis_tready is 0 in that cycle.
REQ-017 s_axis_tready is combinational: 1 in DATA and DROP while i_xgmii_pause=0, and 0 otherwise.
REQ-018 IDLE: register idle word (txd 0x07070707, txc 1111); on tvalid=1, register start word (txd 0x555555FB, txc 0001) and go to PRE; no data is consumed.
REQ-019 PRE: register preamble word (txd 0xD5555555, txc 0000) and go to DATA.
REQ-020 DATA, tvalid=1, tlast=0: register tdata with txc 0000 and stay in DATA.
REQ-021 DATA, tlast=1, tkeep=1111: register tdata with txc 0000 and go to TERM.
REQ-022 DATA, tlast=1, tkeep=0001: register {07,07,FD,d0} with txc 1110 and go to IFG.
REQ-023 DATA, tlast=1, tkeep=0011: register {07,FD,d1,d0} with txc 1100 and go to IFG.
REQ-024 DATA, tlast=1, tkeep=0111: register {FD,d2,d1,d0} with txc 1000 and go to IFG.
REQ-025 Any other tkeep on tlast (including 0000) is treated as 1111.
REQ-026 TERM: register 0x070707FD with txc 1111 and go to IFG.
REQ-027 o_frame_cnt increments on the edge that registers the terminate character.
REQ-028 DATA, tvalid=0 (underrun): register error word 0xFEFEFEFE with txc 1111, pulse o_underrun for one cycle, and go to DROP; o_frame_cnt does not increment.
REQ-029 DROP: register idle words and discard accepted words; on an accepted word with tlast=1, go to IFG.
REQ-030 IFG: register idle words, counting the idle words registered; after IFG_WORDS idle words, go to IDLE.
REQ-031 tvalid is ignored in IFG and PRE.
REQ-032 Minimum gap from a terminate word to the next start word is IFG_WORDS idle words plus one IDLE-state idle word.
REQ-033 Any state encoding not defined above returns to IDLE and registers the idle word.

Reset
REQ-034 Asserting i_reset_n=0 at any time, including mid-frame, immediately sets: state IDLE; txd 0x07070707; txc 1111; o_frame_cnt 0; IFG counter 0; o_underrun 0.
REQ-035 After release, the first frame starts only from IDLE; any partially sent frame is not resumed.

Verification
REQ-036 Single frame of two words (0x04030201, then 0x08070605 with tlast, tkeep 1111) -> txd sequence 555555FB/0001, D5555555/0000, 04030201/0000, 08070605/0000, 070707FD/1111, then 2 idle words, then idle; o_frame_cnt=1.
REQ-037 Single-word frames with last tkeep 0001, 0011 and 0111 each -> terminate words 0707FDxx/1110, 07FDxxxx/1100 and FDxxxxxx/1000 respectively.
REQ-038 Drop tvalid for one cycle mid-frame -> FEFEFEFE/1111 and an o_underrun pulse; remaining words are drained until tlast, then IFG; o_frame_cnt is unchanged.
REQ-039 Assert i_xgmii_pause for one cycle during DATA and for one cycle during IFG -> outputs and tready hold; no word is lost or duplicated; the IFG still contains exactly IFG_WORDS idle words.
REQ-040 Back-to-back frames with tvalid held high -> the gap between 070707FD and the next 555555FB is exactly 3 idle words (IFG_WORDS=2).
REQ-041 Reset asserted mid-DATA -> outputs go to idle/1111 with no clock edge; after release, a new frame is framed correctly and o_frame_cnt restarts from 0.

Source files
------------

// File: rtl/xgmii_tx_sequencer.sv
// XGMII transmit sequencer: wraps an AXI-Stream frame in start/preamble/terminate
// control characters, enforces the inter-frame gap and handles mid-frame underrun.
module xgmii_tx_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4,
    parameter int IFG_WORDS  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CTRL_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic                  i_xgmii_pause,
    output logic [DATA_WIDTH-1:0] o_xgmii_txd,
    output logic [CTRL_WIDTH-1:0] o_xgmii_txc,
    output logic                  o_busy,
    output logic                  o_underrun,
    output logic [15:0]           o_frame_cnt
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_TERM = 3'd3;
    localparam logic [2:0] ST_IFG  = 3'd4;
    localparam logic [2:0] ST_DROP = 3'd5;

    localparam logic [31:0] IDLE_WORD  = 32'h07070707;
    localparam logic [31:0] START_WORD = 32'h555555FB;
    localparam logic [31:0] PRE_WORD   = 32'hD5555555;
    localparam logic [31:0] TERM_WORD  = 32'h070707FD;
    localparam logic [31:0] ERR_WORD   = 32'hFEFEFEFE;
    localparam logic [3:0]  IFG_LIMIT  = 4'(IFG_WORDS);

    logic [2:0]            r_state;
    logic [DATA_WIDTH-1:0] r_txd;
    logic [CTRL_WIDTH-1:0] r_txc;
    logic [15:0]           r_frame_cnt;
    logic [3:0]            r_ifg_cnt;
    logic                  r_underrun;

    logic [2:0]            w_next_state;
    logic [DATA_WIDTH-1:0] w_txd;
    logic [CTRL_WIDTH-1:0] w_txc;
    logic                  w_frame_inc;
    logic [3:0]            w_ifg_cnt;
    logic                  w_underrun;

    assign s_axis_tready = ((r_state == ST_DATA) || (r_state == ST_DROP)) && !i_xgmii_pause;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_xgmii_txd   = r_txd;
    assign o_xgmii_txc   = r_txc;
    assign o_underrun    = r_underrun;
    assign o_frame_cnt   = r_frame_cnt;

    // Next-state and next-output-word decode for one unpaused edge
    always_comb begin
        w_next_state = r_state;
        w_txd        = IDLE_WORD;
        w_txc        = 4'b1111;
        w_frame_inc  = 1'b0;
        w_ifg_cnt    = r_ifg_cnt;
        w_underrun   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    w_txd        = START_WORD;
                    w_txc        = 4'b0001;
                    w_next_state = ST_PRE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_PRE: begin
                w_txd        = PRE_WORD;
                w_txc        = 4'b0000;
                w_next_state = ST_DATA;
            end
            ST_DATA: begin
                if (!s_axis_tvalid) begin
                    w_txd        = ERR_WORD;
                    w_txc        = 4'b1111;
                    w_underrun   = 1'b1;
                    w_next_state = ST_DROP;
                end else if (!s_axis_tlast) begin
                    w_txd = s_axis_tdata;
                    w_txc = 4'b0000;
                end else begin
                    // Partial last beats carry the terminate inline; anything else needs a TERM word
                    w_ifg_cnt = 4'd0;
                    case (s_axis_tkeep)
                        4'b0001: begin
                            w_txd        = {8'h07, 8'h07, 8'hFD, s_axis_tdata[7:0]};
                            w_txc        = 4'b1110;
                            w_frame_inc  = 1'b1;
                            w_next_state = ST_IFG;
                        end
                        4'b0011: begin
                            w_txd        = {8'h07, 8'hFD, s_axis_tdata[15:0]};
                            w_txc        = 4'b1100;
                            w_frame_inc  = 1'b1;
                            w_next_state = ST_IFG;
                        end
                        4'b0111: begin
                            w_txd        = {8'hFD, s_axis_tdata[23:0]};
                            w_txc        = 4'b1000;
                            w_frame_inc  = 1'b1;
                            w_next_state = ST_IFG;
                        end
                        default: begin
                            w_txd        = s_axis_tdata;
                            w_txc        = 4'b0000;
                            w_next_state = ST_TERM;
                        end
                    endcase
                end
            end
            ST_TERM: begin
                w_txd        = TERM_WORD;
                w_txc        = 4'b1111;
                w_frame_inc  = 1'b1;
                w_ifg_cnt    = 4'd0;
                w_next_state = ST_IFG;
            end
            ST_IFG: begin
                // The idle after IFG_WORDS counted idles is the one owed to IDLE
                if (r_ifg_cnt >= IFG_LIMIT) begin
                    w_ifg_cnt    = 4'd0;
                    w_next_state = ST_IDLE;
                end else begin
                    w_ifg_cnt    = r_ifg_cnt + 4'd1;
                    w_next_state = ST_IFG;
                end
            end
            ST_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_ifg_cnt    = 4'd0;
                    w_next_state = ST_IFG;
                end else begin
                    w_next_state = ST_DROP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, output word and counters; everything freezes while the encoder pauses
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_txd       <= IDLE_WORD;
            r_txc       <= 4'b1111;
            r_frame_cnt <= 16'd0;
            r_ifg_cnt   <= 4'd0;
            r_underrun  <= 1'b0;
        end else if (i_xgmii_pause) begin
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_txd       <= w_txd;
            r_txc       <= w_txc;
            r_frame_cnt <= r_frame_cnt + {15'd0, w_frame_inc};
            r_ifg_cnt   <= w_ifg_cnt;
            r_underrun  <= w_underrun;
        end
    end

endmodule

// File: tb/tb_xgmii_tx_sequencer.sv
// Scoreboard bench for xgmii_tx_sequencer: directed frames push expected XGMII words,
// a monitor pops and compares every word the encoder consumes.
module tb_xgmii_tx_sequencer;

    typedef logic [36:0] ent_t;   // {txd, txc, underrun}

    localparam ent_t IDLE_E = {32'h07070707, 4'b1111, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] tdata = 32'd0;
    logic [3:0]  tkeep = 4'd0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic        pause = 1'b0;
    logic [31:0] txd;
    logic [3:0]  txc;
    logic        busy;
    logic        und;
    logic [15:0] fcnt;

    int   checks = 0;
    int   failures = 0;
    int   idle_run = 0;
    bit   mon_en = 1'b0;
    ent_t q[$];
    int   gaps[$];

    xgmii_tx_sequencer #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .IFG_WORDS(2)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast), .s_axis_tready(tready), .i_xgmii_pause(pause),
        .o_xgmii_txd(txd), .o_xgmii_txc(txc), .o_busy(busy),
        .o_underrun(und), .o_frame_cnt(fcnt)
    );

    always #5 clk = ~clk;

    function automatic ent_t ew(input logic [31:0] d, input logic [3:0] c, input logic u);
        return {d, c, u};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic push_idles(input int n);
        for (int i = 0; i < n; i++) q.push_back(IDLE_E);
    endtask

    // Words consumed by the encoder are compared; extra idles between frames are skipped
    task automatic monitor();
        logic live;
        ent_t got;
        ent_t exp;
        forever begin
            @(posedge clk);
            live = !pause && rst_n;
            @(negedge clk);
            if (live && mon_en) begin
                got = {txd, txc, und};
                if (got == IDLE_E) idle_run++;
                if (q.size() > 0 && !(got == IDLE_E && q[0] != IDLE_E)) begin
                    exp = q.pop_front();
                    checks++;
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL word: got txd=%h txc=%b und=%b required txd=%h txc=%b und=%b",
                                 got[36:5], got[4:1], got[0], exp[36:5], exp[4:1], exp[0]);
                    end
                end else if (got != IDLE_E) begin
                    checks++;
                    failures++;
                    $display("FAIL word: got unexpected txd=%h txc=%b und=%b required idle",
                             got[36:5], got[4:1], got[0]);
                end
                if (got[36:1] == {32'h555555FB, 4'b0001}) gaps.push_back(idle_run);
                if (got != IDLE_E) idle_run = 0;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input bit pause_first);
        bit acc;
        int n;
        tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
        if (pause_first) begin
            pause = 1'b1;
            #1;
            chk("tready_in_pause", {31'd0, tready}, 32'd0);
            @(posedge clk); #1;
            pause = 1'b0;
        end
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = tready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: got no tready required accept of %h", d);
        end
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0; tlast = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state, checked before the first clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("reset_txd", txd, 32'h07070707);
        chk("reset_txc", {28'd0, txc}, 32'hF);
        chk("reset_cnt", {16'd0, fcnt}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Two-word frame, full keep
        q.push_back(ew(32'h555555FB, 4'b0001, 1'b0));
        q.push_back(ew(32'hD5555555, 4'b0000, 1'b0));
        q.push_back(ew(32'h04030201, 4'b0000, 1'b0));
        q.push_back(ew(32'h08070605, 4'b0000, 1'b0));
        q.push_back(ew(32'h070707FD, 4'b1111, 1'b0));
        push_idles(3);
        send(32'h04030201, 4'b1111, 1'b0, 1'b0);
        send(32'h08070605, 4'b1111, 1'b1, 1'b0);
        idle(8);
        chk("frame_cnt_1", {16'd0, fcnt}, 32'd1);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);

        // Single-word frames with partial and illegal keep values
        q.push_back(ew(32'h555555FB, 4'b0001, 1'b0));
        q.push_back(ew(32'hD5555555, 4'b0000, 1'b0));
        q.push_back(ew(32'h0707FD11, 4'b1110, 1'b0));
        push_idles(3);
        send(32'h44332211, 4'b0001, 1'b1, 1'b0);
        idle(6);
        q.push_back(ew(32'h555555FB, 4'b0001, 1'b0));
        q.push_back(ew(32'hD5555555, 4'b0000, 1'b0));
        q.push_back(ew(32'h07FD6655, 4'b1100, 1'b0));
        push_idles(3);
        send(32'h88776655, 4'b0011, 1'b1, 1'b0);
        idle(6);
        q.push_back(ew(32'h555555FB, 4'b0001, 1'b0));
        q.push_back(ew(32'hD5555555, 4'b0000, 1'b0));
        q.push_back(ew(32'hFDBBAA99, 4'b1000, 1'b0));
        push_idles(3);
        send(32'hCCBBAA99, 4'b0111, 1'b1, 1'b0);
        idle(6);
        q.push_back(ew(32'h555555FB, 4'b0001, 1'b0));
        q.push_back(ew(32'hD5555555, 4'b0000, 1'b0));
        q.push_back(ew(32'hDEADBEEF, 4'b0000, 1'b0));
        q.push_back(ew(32'h070707FD, 4'b1111, 1'b0));
        push_idles(3);
        send(32'hDEADBEEF, 4'b0000, 1'b1, 1'b0);
        idle(8);
        chk("frame_cnt_5", {16'd0, fcnt}, 32'd5);

        // Underrun mid-frame, remainder drained
        q.push_back(ew(32'h555555FB, 4'b0001, 1'b0));
        q.push_back(ew(32'hD5555555, 4'b0000, 1'b0));
        q.push_back(ew(32'h11111111, 4'b0000, 1'b0));
        q.push_back(ew(32'hFEFEFEFE, 4'b1111, 1'b1));
        send(32'h11111111, 4'b1111, 1'b0, 1'b0);
        idle(1);
        send(32'h22222222, 4'b1111, 1'b0, 1'b0);
        send(32'h33333333, 4'b1111, 1'b1, 1'b0);
        idle(8);
        chk("frame_cnt_underrun", {16'd0, fcnt}, 32'd5);

        // Pause in DATA and in IFG, then back-to-back frames with tvalid held high
        gaps.delete();
        q.push_back(ew(32'h555555FB, 4'b0001, 1'b0));
        q.push_back(ew(32'hD5555555, 4'b0000, 1'b0));
        q.push_back(ew(32'hA0A0A001, 4'b0000, 1'b0));
        q.push_back(ew(32'hA0A0A002, 4'b0000, 1'b0));
        q.push_back(ew(32'hA0A0A003, 4'b0000, 1'b0));
        q.push_back(ew(32'h070707FD, 4'b1111, 1'b0));
        push_idles(3);
        q.push_back(ew(32'h555555FB, 4'b0001, 1'b0));
        q.push_back(ew(32'hD5555555, 4'b0000, 1'b0));
        q.push_back(ew(32'hB0B0B001, 4'b0000, 1'b0));
        q.push_back(ew(32'h070707FD, 4'b1111, 1'b0));
        push_idles(3);
        q.push_back(ew(32'h555555FB, 4'b0001, 1'b0));
        q.push_back(ew(32'hD5555555, 4'b0000, 1'b0));
        q.push_back(ew(32'h0707FDC1, 4'b1110, 1'b0));
        push_idles(3);
        send(32'hA0A0A001, 4'b1111, 1'b0, 1'b0);
        send(32'hA0A0A002, 4'b1111, 1'b0, 1'b1);
        send(32'hA0A0A003, 4'b1111, 1'b1, 1'b0);
        tdata = 32'hB0B0B001; tkeep = 4'b1111; tlast = 1'b1; tvalid = 1'b1;
        @(posedge clk); #1;
        pause = 1'b1;
        #1;
        chk("tready_in_ifg_pause", {31'd0, tready}, 32'd0);
        @(posedge clk); #1;
        pause = 1'b0;
        send(32'hB0B0B001, 4'b1111, 1'b1, 1'b0);
        send(32'h000000C1, 4'b0001, 1'b1, 1'b0);
        idle(8);
        chk("gap_count", gaps.size(), 32'd3);
        if (gaps.size() == 3) begin
            chk("gap_after_paused_ifg", gaps[1], 32'd3);
            chk("gap_back_to_back", gaps[2], 32'd3);
        end
        chk("frame_cnt_8", {16'd0, fcnt}, 32'd8);

        // Asynchronous reset mid-DATA, then a fresh frame
        q.push_back(ew(32'h555555FB, 4'b0001, 1'b0));
        q.push_back(ew(32'hD5555555, 4'b0000, 1'b0));
        q.push_back(ew(32'h12345678, 4'b0000, 1'b0));
        send(32'h12345678, 4'b1111, 1'b0, 1'b0);
        tdata = 32'h9ABCDEF0; tlast = 1'b0;
        @(posedge clk); #1;
        #3;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_txd", txd, 32'h07070707);
        chk("mid_reset_txc", {28'd0, txc}, 32'hF);
        chk("mid_reset_cnt", {16'd0, fcnt}, 32'd0);
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        chk("queue_before_reset", q.size(), 32'd0);
        q.delete();
        tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        q.push_back(ew(32'h555555FB, 4'b0001, 1'b0));
        q.push_back(ew(32'hD5555555, 4'b0000, 1'b0));
        q.push_back(ew(32'hFDFEF00D, 4'b1000, 1'b0));
        push_idles(3);
        send(32'hCAFEF00D, 4'b0111, 1'b1, 1'b0);
        idle(8);
        chk("frame_cnt_after_reset", {16'd0, fcnt}, 32'd1);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        chk("queue_drained", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
